// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side driver for the register file. Results from the execution units
//   arrive over a valid/ready handshake. They are held in an in-order FIFO and
//   retired one per cycle onto the register file write port. Values that are
//   queued but not yet written are forwarded to both read ports, so the
//   datapath never sees stale register contents.
//
//   Optional build macro: WB_COALESCE_EN
//     When this macro is defined, a push to the same register as the youngest
//     queued entry overwrites that entry's data instead of taking a new slot.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   in_valid/in_ready           producer handshake
//   in_addr/in_data             destination register and result value
//   drain_en                    permits retiring the head entry this cycle
//   rf_regWrite/waddr/wdata     register file write port (combinational from head)
//   rd_addr1/rd_addr2           register file read addresses
//   fwd_hit1/2, fwd_data1/2     youngest pending value per read port (0 when no hit)
//   pending                     one bit per register with a queued write
//   count                       number of queued entries
module reg_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   drain_en,
    output logic                   rf_regWrite,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic                   fwd_hit1,
    output logic [DATA_W-1:0]      fwd_data1,
    output logic                   fwd_hit2,
    output logic [DATA_W-1:0]      fwd_data2,
    output logic [(2**ADDR_W)-1:0] pending,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              alloc;
    logic              coalesce;

    assign empty = (count == '0);
    assign full  = (count == FULL);

    // Retire is blocked during reset so no write escapes on the reset edge.
    assign pop         = rst & ~empty & drain_en;
    assign rf_regWrite = pop;
    assign rf_waddr    = empty ? '0 : addr_q[head];
    assign rf_wdata    = empty ? '0 : data_q[head];

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] young;
    logic             young_match;

    assign young       = tail - 1'b1;
    assign young_match = ~empty & (addr_q[young] == in_addr);
    // A full queue can still absorb a push that merges into the youngest entry.
    assign in_ready    = rst & (~full | (in_valid & young_match));
    // If the youngest entry is the head leaving this cycle, merging would lose
    // the write, so a fresh slot is taken instead.
    assign coalesce    = push & young_match & ~((count == ONE) & pop);
`else
    assign in_ready    = rst & ~full;
    assign coalesce    = 1'b0;
`endif

    assign push  = in_valid & in_ready;
    assign alloc = push & ~coalesce;

    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
`ifdef WB_COALESCE_EN
        if (coalesce) begin
            data_q[young] <= in_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (alloc & ~pop) begin
                count <= count + ONE;
            end else if (~alloc & pop) begin
                count <= count - ONE;
            end
        end
    end

    // Walk the entries from oldest to youngest. A later match overrides an
    // earlier one, so the youngest value wins. The head entry being retired
    // this cycle still counts, because the register file updates only at the edge.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        pending   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + (PTR_W)'(i);
            if ((PTR_W+1)'(i) < count) begin
                pending[addr_q[idx]] = 1'b1;
                if (addr_q[idx] == rd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if (addr_q[idx] == rd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

endmodule
